// File: rtl/fp_max_reduce_if.sv
// Handshake bundle for fp_max_reduce: command, element stream, result and status.
// The op_min signal exists only when FP_MAX_REDUCE_MIN_EN is defined.
interface fp_max_reduce_if #(
    parameter int BUS_WIDTH = 64,
    parameter int LEN_W     = 8
);
    logic                 start;
    logic [LEN_W-1:0]     len;
`ifdef FP_MAX_REDUCE_MIN_EN
    logic                 op_min;
`endif
    logic                 in_valid;
    logic                 in_ready;
    logic [BUS_WIDTH-1:0] in_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [BUS_WIDTH-1:0] res_data;
    logic                 res_nan;
    logic                 busy;
    logic [LEN_W-1:0]     count;

`ifdef FP_MAX_REDUCE_MIN_EN
    modport master (
        output start, len, op_min, in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_nan, busy, count
    );
    modport slave (
        input  start, len, op_min, in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_nan, busy, count
    );
`else
    modport master (
        output start, len, in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_nan, busy, count
    );
    modport slave (
        input  start, len, in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_nan, busy, count
    );
`endif
endinterface

// File: rtl/fp_max_reduce.sv
// Streaming IEEE-754 max reduction (single or double) over len elements, NaN-sticky.
// Optional macro FP_MAX_REDUCE_MIN_EN adds op_min, selecting a min reduction per run.
module fp_max_reduce #(
    parameter int BUS_WIDTH = 64,
    parameter int LEN_W     = 8
) (
    input  logic           clk,
    input  logic           rst,
    fp_max_reduce_if.slave bus
);
    localparam int EXP_W = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MAN_W = BUS_WIDTH - 1 - EXP_W;

    localparam logic [BUS_WIDTH-1:0] NEG_INF   = {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [BUS_WIDTH-1:0] POS_INF   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [BUS_WIDTH-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state, state_nxt;
    logic [BUS_WIDTH-1:0] acc;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt;
    logic [LEN_W-1:0]     cnt_inc;
    logic                 nan_q;
    logic                 min_q;
    logic                 accept;
    logic                 in_nan;
    logic [BUS_WIDTH-1:0] pick;
    logic [BUS_WIDTH-1:0] acc_init;

    function automatic logic is_nan(input logic [BUS_WIDTH-1:0] v);
        return (&v[BUS_WIDTH-2 -: EXP_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Returns the winner of a (current acc) against b; ties keep a. Sign-magnitude
    // ordering means the wanted magnitude flips with the sign and with min mode.
    function automatic logic [BUS_WIDTH-1:0] fp_pick(input logic [BUS_WIDTH-1:0] a,
                                                     input logic [BUS_WIDTH-1:0] b,
                                                     input logic             use_min);
        logic b_wins;
        if (is_nan(a) || is_nan(b))
            return CANON_NAN;
        if (a[BUS_WIDTH-1] != b[BUS_WIDTH-1])
            b_wins = (b[BUS_WIDTH-1] == use_min);
        else if (a[BUS_WIDTH-1] ^ use_min)
            b_wins = (b[BUS_WIDTH-2:0] < a[BUS_WIDTH-2:0]);
        else
            b_wins = (b[BUS_WIDTH-2:0] > a[BUS_WIDTH-2:0]);
        return b_wins ? b : a;
    endfunction

`ifdef FP_MAX_REDUCE_MIN_EN
    assign acc_init = bus.op_min ? POS_INF : NEG_INF;
`else
    assign acc_init = NEG_INF;
    assign min_q    = 1'b0;
`endif

    assign cnt_inc = cnt + 1'b1;
    assign accept  = (state == ACCUM) && bus.in_valid;
    assign in_nan  = is_nan(bus.in_data);
    assign pick    = fp_pick(acc, bus.in_data, min_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    state_nxt = (bus.len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (accept && (cnt_inc == len_q))
                    state_nxt = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: acc resets to -inf, not zero, so the register always holds a legal
    // identity value; this is a few flops, not a memory, so resetting it is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= NEG_INF;
            len_q <= '0;
            cnt   <= '0;
            nan_q <= 1'b0;
`ifdef FP_MAX_REDUCE_MIN_EN
            min_q <= 1'b0;
`endif
        end else if (state == IDLE && bus.start) begin
            acc   <= acc_init;
            len_q <= bus.len;
            cnt   <= '0;
            nan_q <= 1'b0;
`ifdef FP_MAX_REDUCE_MIN_EN
            min_q <= bus.op_min;
`endif
        end else if (accept) begin
            acc   <= (nan_q || in_nan) ? CANON_NAN : pick;
            cnt   <= cnt_inc;
            nan_q <= nan_q | in_nan;
        end
    end

    assign bus.res_data = (state == DONE) ? acc : '0;
    assign bus.res_nan  = (state == DONE) && nan_q;
    assign bus.count    = cnt;
endmodule

// File: doc/fp_max_reduce.md
FP_MAX_REDUCE -- requirements
Module: fp_max_reduce

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, operand width; legal values 64 (double) and 32 (single).
REQ-002 SHALL have parameter LEN_W, default 8, width of the element-count field.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a reduction; sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, number of elements to reduce; captured with start.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, BUS_WIDTH): the element stream.
REQ-008 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, BUS_WIDTH): the result.
REQ-009 SHALL have port res_nan, output, 1, set when any accepted element was NaN; valid with res_valid.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port count, output, LEN_W, number of elements accepted in the current reduction.

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-013 IDLE: start=1 with len>0 -> ACCUM; acc loaded with -inf, count=0, nan flag=0.
REQ-014 IDLE: start=1 with len=0 -> DONE directly; res_data=-inf, res_nan=0.
REQ-015 in_ready SHALL be 1 only in ACCUM; an element is accepted on in_valid & in_ready.
REQ-016 On each accept: acc <= max(acc, in_data); count <= count+1.
REQ-017 Accepting the element that makes count equal to len SHALL move the FSM to DONE; res_valid is asserted in the following cycle (one-cycle latency from the last accept).
REQ-018 DONE: res_valid=1 and res_data=acc, both held stable until res_ready=1; that handshake returns the FSM to IDLE.
REQ-019 start SHALL be ignored outside IDLE, including in the handshake cycle of DONE; a new reduction needs start in a later IDLE cycle.
REQ-020 max() rule, any NaN: a NaN is any exponent all-ones with nonzero mantissa. Either operand NaN -> canonical NaN (0x7FF8000000000000 for 64-bit, 0x7FC00000 for 32-bit) and the nan flag is set.
REQ-021 max() rule, NaN persistence: once the nan flag is set, acc SHALL stay the canonical NaN for the rest of the reduction.
REQ-022 max() rule, infinity: +inf wins over every non-NaN value.
REQ-023 max() rule, mixed signs: the positive operand wins, so +0 beats -0.
REQ-024 max() rule, same sign: compare {exponent, mantissa}; for positive operands the larger magnitude wins, for negative operands the smaller magnitude wins.
REQ-025 max() rule, equal operands: the encoding already in acc is kept.
REQ-026 max() SHALL be combinational inside the block; no external comparator.
REQ-027 Denormals SHALL be compared by raw encoding under the same rules, with no flush-to-zero.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, in_ready=0, res_valid=0, res_data=0, res_nan=0, busy=0, count=0, acc=-inf.
REQ-029 rst asserted mid-reduction SHALL discard the partial result; no res_valid follows.

Configuration
REQ-030 With macro FP_MAX_REDUCE_MIN_EN defined, the block SHALL add port op_min (input, 1), captured with start. When the captured op_min=1, acc initialises to +inf and the min rule applies: NaN rules unchanged, -inf wins over every non-NaN value, -0 beats +0, and the magnitude ordering of REQ-024 is reversed.
REQ-031 Without FP_MAX_REDUCE_MIN_EN, port op_min SHALL NOT exist and only max is performed.

Verification
REQ-032 BUS_WIDTH=32, len=3, elements 0x3F800000, 0xC0000000, 0x40400000 -> res_data=0x40400000, res_nan=0, res_valid one cycle after the third accept.
REQ-033 BUS_WIDTH=64, len=2, elements 0x8000000000000000, 0x0000000000000000 -> res_data=0x0000000000000000; both elements negative (-1.0, -2.0) -> res_data=0xBFF0000000000000.
REQ-034 BUS_WIDTH=32, len=4, third element 0x7F800001 and fourth 0x7F800000 -> res_data=0x7FC00000, res_nan=1.
REQ-035 len=0 start -> res_valid next cycle with res_data=-inf (0xFF800000 for 32-bit); hold res_ready=0 for 5 cycles -> res_data stable, start pulses ignored.
REQ-036 Assert rst after 2 of 5 elements accepted -> outputs at reset values immediately; a new start with len=1, element 0x3F800000 -> res_data=0x3F800000, count=1.
REQ-037 With FP_MAX_REDUCE_MIN_EN, op_min=1, BUS_WIDTH=32, elements 0x3F800000, 0xFF800000 -> res_data=0xFF800000.
